// File: rtl/save_backup_ctrl.sv
// Sector-by-sector save RAM copy between the SD image and the cart backup port; requests rise one cycle after the trigger.
// Backpressure is the SD core's sd_ack handshake: each request is held until ack, and each sector ends when ack drops.
module save_backup_ctrl #(
    parameter int SECTOR_WORDS = 256,
    parameter int LBA_BITS     = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    input  logic        bk_save,
    input  logic        has_save,
    input  logic [7:0]  ram_mask_file,
    input  logic        cram_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data,
    output logic        bk_wr,
    input  logic [15:0] bk_q,
    output logic        bk_busy,
    output logic        bk_loading,
    output logic        dirty
);
    localparam int WORD_BITS = $clog2(SECTOR_WORDS);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER, NEXT} state_t;

    state_t              state;
    logic [LBA_BITS-1:0] lba;
    logic [LBA_BITS-1:0] last;
    logic                mounted;
    logic                save_q;
    logic                abort_pend;

    logic                save_rise;
    logic                unmount;
    logic                abort;
    logic                load_go;
    logic                save_go;
    logic [LBA_BITS-1:0] img_last;
    logic [LBA_BITS-1:0] mask_last;

    assign save_rise = bk_save & ~save_q;
    assign unmount   = img_mounted && (img_size == '0);
    assign abort     = abort_pend || unmount;
    assign img_last  = img_size[WORD_BITS+1 +: LBA_BITS] - 1'b1;
    assign mask_last = LBA_BITS'(ram_mask_file);
    // An image shorter than one sector never starts a load.
    assign load_go   = img_mounted && (img_size >= 64'd512) && has_save;
    assign save_go   = save_rise && mounted && !img_readonly && has_save && dirty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lba        <= '0;
            last       <= '0;
            mounted    <= 1'b0;
            save_q     <= 1'b0;
            abort_pend <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            dirty      <= 1'b0;
        end else begin
            save_q <= bk_save;
            if (img_mounted)
                mounted <= (img_size != '0);
            if (state != IDLE && unmount)
                abort_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (load_go) begin
                        lba        <= '0;
                        last       <= (mask_last < img_last) ? mask_last : img_last;
                        bk_loading <= 1'b1;
                        sd_rd      <= 1'b1;
                        state      <= RD_REQ;
                    end else if (save_go) begin
                        lba   <= '0;
                        last  <= mask_last;
                        sd_wr <= 1'b1;
                        state <= WR_REQ;
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (abort && !sd_ack) begin
                        sd_rd      <= 1'b0;
                        sd_wr      <= 1'b0;
                        bk_loading <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= IDLE;
                    end else if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= (state == RD_REQ) ? RD_XFER : WR_XFER;
                    end
                end
                RD_XFER, WR_XFER: begin
                    if (!sd_ack) begin
                        if (abort) begin
                            bk_loading <= 1'b0;
                            abort_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (abort) begin
                        bk_loading <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= IDLE;
                    end else if (lba == last) begin
                        bk_loading <= 1'b0;
                        dirty      <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lba <= lba + 1'b1;
                        if (bk_loading) begin
                            sd_rd <= 1'b1;
                            state <= RD_REQ;
                        end else begin
                            sd_wr <= 1'b1;
                            state <= WR_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the completion clear so a write landing on save completion survives;
            // during a load bk_loading is still high, so the clear wins there.
            if (cram_wr && has_save && !bk_loading)
                dirty <= 1'b1;
        end
    end

    assign bk_busy     = (state != IDLE);
    assign sd_lba      = 32'(lba);
    assign bk_addr     = 17'({lba, sd_buff_addr[WORD_BITS-1:0]});
    assign bk_data     = sd_buff_dout;
    assign bk_wr       = sd_buff_wr & sd_ack & bk_loading;
    assign sd_buff_din = bk_q;

endmodule
